handshake_packer: RTL

HANDSHAKE_PACKER -- requirements
Module: handshake_packer

---
 rtl/handshake_packer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/handshake_packer.sv
// Packs RATIO narrow input beats, fetched over a req/gnt bus handshake, into one
// wide word and queues finished words in a DEPTH-entry FIFO for the consumer.
module handshake_packer #(
    parameter int IN_W      = 8,
    parameter int RATIO     = 8,
    parameter int DEPTH     = 2,
    parameter int MSB_FIRST = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         gnt,
    input  logic                         in_valid,
    input  logic [IN_W-1:0]              in_data,
    input  logic                         accepted,
    output logic [IN_W*RATIO-1:0]        out_data,
    output logic                         ready,
    output logic                         req,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int OUT_W = IN_W * RATIO;
    localparam int CNT_W = $clog2(RATIO);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]   slot;
    logic [OUT_W-1:0]   word_acc;
    logic [OUT_W-1:0]   next_acc;
    logic [OUT_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level_popped;
    logic [LVL_W-1:0]   level_next;
    logic               take;
    logic               push;
    logic               pop;

    assign take     = (state == COLLECT) && gnt && in_valid;
    assign push     = take && (beat_cnt == LAST_BEAT);
    assign pop      = ready && accepted;
    assign slot     = (MSB_FIRST != 0) ? (LAST_BEAT - beat_cnt) : beat_cnt;
    assign ready    = (level != '0);
    assign req      = (state == COLLECT);
    assign out_data = ready ? mem[rd_ptr] : '0;

    // The word written to the FIFO already contains the beat arriving on the same edge.
    always_comb begin
        next_acc = word_acc;
        for (int i = 0; i < RATIO; i++) begin
            if (take && (slot == CNT_W'(i))) begin
                next_acc[i*IN_W +: IN_W] = in_data;
            end
        end
    end

    always_comb begin
        level_popped = pop ? (level - LVL_W'(1)) : level;
        level_next   = push ? (level_popped + LVL_W'(1)) : level_popped;
    end

    // Room is judged on the post-edge level, so a same-edge pop can reopen collection.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && (level_popped < FULL_LVL)) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (push) begin
                    state_next = (start && (level_next < FULL_LVL)) ? COLLECT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            word_acc <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
        end else begin
            state    <= state_next;
            word_acc <= next_acc;
            level    <= level_next;
            if (take) begin
                beat_cnt <= push ? '0 : (beat_cnt + CNT_W'(1));
            end
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : (wr_ptr + PTR_W'(1));
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : (rd_ptr + PTR_W'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= next_acc;
        end
    end

endmodule
